cmac_accumulator: RTL and testbench

- Complex multiply-accumulate stage directly downstream of the complex fixed-point multiplier in the combinational QFT datapath.
- Consumes a stream of complex products (pr, pi) with a valid/ready handshake.
- Sums N_TERMS consecutive products into one DFT/QFT output amplitude, applies an optional arithmetic right shift for normalisation, saturates to the datapath width, and emits one complex result per N_TERMS accepted inputs.

---
 rtl/cmac_accumulator.sv | 110 +++++++++++
 tb/tb_cmac_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_accumulator.sv
// Complex multiply-accumulate stage: sums N_TERMS complex products,
// shifts, saturates and emits one result per N_TERMS accepted inputs.
module cmac_accumulator #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 12,
    parameter int N_TERMS   = 8,
    parameter int GUARD_W   = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_sat,
    output logic                     busy
);

    localparam int ACC_W = DATA_W + GUARD_W;
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] SMAX =
        {{(GUARD_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN =
        {{(GUARD_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    if (N_TERMS < 1) begin : g_bad_terms
        $error("N_TERMS must be at least 1");
    end
    if ((1 << GUARD_W) < N_TERMS) begin : g_bad_guard
        $error("GUARD_W too small for N_TERMS");
    end
    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $error("FRAC_W must be below DATA_W");
    end

    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;
    logic [DATA_W:0]         res_re;
    logic [DATA_W:0]         res_im;
    logic [CNT_W-1:0]        cnt;
    logic                    last;
    logic                    accept;
    logic                    fire;

    // Returns {clipped, value} after the normalising shift.
    function automatic logic [DATA_W:0] shift_sat(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] s;
        s = v >>> OUT_SHIFT;
        if (s > SMAX) begin
            return {1'b1, SMAX[DATA_W-1:0]};
        end else if (s < SMIN) begin
            return {1'b1, SMIN[DATA_W-1:0]};
        end
        return {1'b0, s[DATA_W-1:0]};
    endfunction

    assign last     = (cnt == LAST);
    assign fire     = out_valid && out_ready;
    assign in_ready = !rst && !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0);

    assign sum_re = acc_re + {{GUARD_W{in_re[DATA_W-1]}}, in_re};
    assign sum_im = acc_im + {{GUARD_W{in_im[DATA_W-1]}}, in_im};
    assign res_re = shift_sat(sum_re);
    assign res_im = shift_sat(sum_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re    <= '0;
            acc_im    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (fire) begin
                out_valid <= 1'b0;
            end
            // A last-term accept overrides the drain in the same cycle.
            if (accept) begin
                if (last) begin
                    out_re    <= res_re[DATA_W-1:0];
                    out_im    <= res_im[DATA_W-1:0];
                    out_sat   <= res_re[DATA_W] | res_im[DATA_W];
                    out_valid <= 1'b1;
                    acc_re    <= '0;
                    acc_im    <= '0;
                    cnt       <= '0;
                end else begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    cnt    <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmac_accumulator.sv
// Bench for cmac_accumulator: directed cases plus random traffic
// against an arithmetic reference model, shifts 0 and 3 side by side.
module tb_cmac_accumulator;

    localparam int DW = 16;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [DW-1:0] in_re = '0;
    logic signed [DW-1:0] in_im = '0;

    logic in_ready0, out_valid0, out_sat0, busy0;
    logic in_ready3, out_valid3, out_sat3, busy3;
    logic signed [DW-1:0] out_re0, out_im0, out_re3, out_im3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int re0;
        int im0;
        int sat0;
        int re3;
        int im3;
        int sat3;
    } exp_t;

    exp_t q[$];
    int   n  = 0;
    int   sr = 0;
    int   si = 0;

    always #5 clk = ~clk;

    cmac_accumulator u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_re(out_re0), .out_im(out_im0),
        .out_sat(out_sat0), .busy(busy0)
    );

    cmac_accumulator #(.OUT_SHIFT(3)) u3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_re(out_re3), .out_im(out_im3),
        .out_sat(out_sat3), .busy(busy3)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic exp_t make(input int r, input int i);
        exp_t e;
        int r3, i3;
        r3 = r >>> 3;
        i3 = i >>> 3;
        e.re0  = clampv(r);
        e.im0  = clampv(i);
        e.sat0 = int'((e.re0 != r) || (e.im0 != i));
        e.re3  = clampv(r3);
        e.im3  = clampv(i3);
        e.sat3 = int'((e.re3 != r3) || (e.im3 != i3));
        return e;
    endfunction

    // Reference model: the state it holds describes the DUT after the
    // previous rising edge; this cycle's handshakes are folded in last.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rdy_rst0", in_ready0, 0);
                chk("rdy_rst3", in_ready3, 0);
                n = 0; sr = 0; si = 0;
                q.delete();
            end else begin
                chk("busy0", busy0, n != 0);
                chk("busy3", busy3, n != 0);
                chk("oval0", out_valid0, q.size() != 0);
                chk("oval3", out_valid3, q.size() != 0);
                chk("rdy0", in_ready0,
                    !(n == N - 1 && q.size() != 0 && !out_ready));
                chk("rdy3", in_ready3,
                    !(n == N - 1 && q.size() != 0 && !out_ready));
                if (q.size() != 0 && out_valid0) begin
                    chk("re0", out_re0, q[0].re0);
                    chk("im0", out_im0, q[0].im0);
                    chk("sat0", out_sat0, q[0].sat0);
                    chk("re3", out_re3, q[0].re3);
                    chk("im3", out_im3, q[0].im3);
                    chk("sat3", out_sat3, q[0].sat3);
                    if (out_ready) void'(q.pop_front());
                end
                if (in_valid && in_ready0) begin
                    sr += int'(in_re);
                    si += int'(in_im);
                    n++;
                    if (n == N) begin
                        q.push_back(make(sr, si));
                        n = 0; sr = 0; si = 0;
                    end
                end
            end
        end
    end

    task automatic send(input int re, input int im);
        in_valid = 1'b1;
        in_re = DW'(re);
        in_im = DW'(im);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready0) break;
        end
        chk("send_rdy", in_ready0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic burst(input int cnt, input int re, input int im);
        for (int k = 0; k < cnt; k++) send(re, im);
    endtask

    function automatic int rnd();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oval", out_valid0, 0);
        chk("rst_re", out_re0, 0);
        chk("rst_im", out_im0, 0);
        chk("rst_sat", out_sat0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_rdy", in_ready0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_rdy", in_ready0, 1);

        burst(7, 512, -512);
        chk("scale_early", out_valid0, 0);
        send(512, -512);
        chk("scale_oval", out_valid0, 1);
        chk("scale_re", out_re0, 4096);
        chk("scale_im", out_im0, -4096);
        chk("scale_sat", out_sat0, 0);
        @(posedge clk);
        #1;
        chk("scale_1cyc", out_valid0, 0);

        burst(8, 4096, 0);
        chk("psat_re", out_re0, 32767);
        chk("psat_im", out_im0, 0);
        chk("psat_sat", out_sat0, 1);

        burst(8, -4096, -4096);
        chk("nmin_re", out_re0, -32768);
        chk("nmin_im", out_im0, -32768);
        chk("nmin_sat", out_sat0, 0);

        burst(8, 4096, 1);
        chk("sh3_re", out_re3, 4096);
        chk("sh3_im", out_im3, 1);
        chk("sh3_sat", out_sat3, 0);
        send(-1, 0);
        burst(7, 0, 0);
        chk("sh3_neg_re", out_re3, -1);
        chk("sh3_neg_im", out_im3, 0);
        chk("sh0_neg_re", out_re0, -1);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_re = DW'(k);
            in_im = DW'(-k);
            @(negedge clk);
            if (k < 16) begin
                chk("bp_rdy", in_ready0, 1);
                @(posedge clk);
                #1;
            end else begin
                chk("bp_stall", in_ready0, 0);
            end
        end
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_rdy", in_ready0, 0);
            chk("bp_hold_oval", out_valid0, 1);
            chk("bp_hold_re", out_re0, 36);
            chk("bp_hold_im", out_im0, -36);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", in_ready0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp2_oval", out_valid0, 1);
        chk("bp2_re", out_re0, 100);
        chk("bp2_im", out_im0, -100);
        @(posedge clk);
        #1;
        chk("bp2_drain", out_valid0, 0);

        out_ready = 1'b0;
        burst(8, 5, 5);
        burst(5, 77, -3);
        chk("mid_busy", busy0, 1);
        chk("mid_oval", out_valid0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", busy0, 0);
        chk("mrst_oval", out_valid0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mrst_busy_after", busy0, 0);
        chk("mrst_oval_after", out_valid0, 0);
        burst(8, 1, 1);
        chk("mrst_re", out_re0, 8);
        chk("mrst_im", out_im0, 8);
        chk("mrst_re3", out_re3, 1);
        chk("mrst_im3", out_im3, 1);

        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_re     = DW'(rnd());
            in_im     = DW'(rnd());
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 150) == 0);
            @(posedge clk);
            #1;
        end

        in_valid  = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
